// File: rtl/wb_stage_if.sv
// Memory-stage to write-back-stage handshake: one instruction offer plus the
// fields the write-back stage needs to finish it.
interface wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [31:0]       ms_pc;
    logic              ms_gr_we;
    logic [ADDR_W-1:0] ms_dest;
    logic [DATA_W-1:0] ms_res;
    logic [2:0]        ms_ld_op;
    logic [1:0]        ms_addr_lo;
    logic [DATA_W-1:0] ms_rt_val;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_res,
               ms_ld_op, ms_addr_lo, ms_rt_val,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_res,
               ms_ld_op, ms_addr_lo, ms_rt_val,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, waits for load data, extracts and
// merges it, and drives the register-file write port, forwarding bus and trace.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    wb_stage_if.slave         ms,
    input  logic              data_rdata_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [3:0]        rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ws_fwd_valid,
    output logic [ADDR_W-1:0] ws_fwd_dest,
    output logic              ws_fwd_data_ok,
    output logic [DATA_W-1:0] ws_fwd_data,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);
    localparam int unsigned NBYTES = 4;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0, LD_B  = 3'd1, LD_BU = 3'd2, LD_H  = 3'd3,
        LD_HU   = 3'd4, LD_W  = 3'd5, LD_WL = 3'd6, LD_WR = 3'd7
    } ld_op_e;

    logic              ws_valid_q, ws_valid_d;
    logic [31:0]       pc_q, pc_d;
    logic              gr_we_q, gr_we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] res_q, res_d;
    ld_op_e            ld_op_q, ld_op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;

    logic              ws_ready_go;
    logic              write_cycle;
    logic              wr_en;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] shifted;
    logic [3:0]        wb_mask;
    logic [DATA_W-1:0] wb_data;

    assign ws_ready_go   = (ld_op_q == LD_NONE) | data_rdata_ok;
    assign ms.ws_allowin = !ws_valid_q | ws_ready_go;
    assign write_cycle   = ws_valid_q & ws_ready_go;
    assign wr_en         = ws_valid_q & gr_we_q & (dest_q != '0);

    // Pipeline register: a stalled load keeps every field until its data arrives.
    always_comb begin
        ws_valid_d = ws_valid_q;
        pc_d       = pc_q;
        gr_we_d    = gr_we_q;
        dest_d     = dest_q;
        res_d      = res_q;
        ld_op_d    = ld_op_q;
        addr_lo_d  = addr_lo_q;
        rt_val_d   = rt_val_q;
        if (ms.ms_to_ws_valid && ms.ws_allowin) begin
            ws_valid_d = 1'b1;
            pc_d       = ms.ms_pc;
            gr_we_d    = ms.ms_gr_we;
            dest_d     = ms.ms_dest;
            res_d      = ms.ms_res;
            ld_op_d    = ld_op_e'(ms.ms_ld_op);
            addr_lo_d  = ms.ms_addr_lo;
            rt_val_d   = ms.ms_rt_val;
        end else if (ws_ready_go) begin
            ws_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_valid_q <= 1'b0;
            pc_q       <= '0;
            gr_we_q    <= 1'b0;
            dest_q     <= '0;
            res_q      <= '0;
            ld_op_q    <= LD_NONE;
            addr_lo_q  <= '0;
            rt_val_q   <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            pc_q       <= pc_d;
            gr_we_q    <= gr_we_d;
            dest_q     <= dest_d;
            res_q      <= res_d;
            ld_op_q    <= ld_op_d;
            addr_lo_q  <= addr_lo_d;
            rt_val_q   <= rt_val_d;
        end
    end

    // Load extraction; lwl/lwr shift the word into place and keep rt in the other bytes.
    always_comb begin
        ld_byte = data_rdata[{addr_lo_q, 3'b000} +: 8];
        ld_half = data_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        shifted = data_rdata;
        wb_mask = 4'b1111;
        wb_data = res_q;
        case (ld_op_q)
            LD_B:  wb_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LD_BU: wb_data = {{(DATA_W-8){1'b0}}, ld_byte};
            LD_H:  wb_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LD_HU: wb_data = {{(DATA_W-16){1'b0}}, ld_half};
            LD_W:  wb_data = data_rdata;
            LD_WL: begin
                shifted = data_rdata << {2'(2'd3 - addr_lo_q), 3'b000};
                wb_mask = 4'b1111 << 2'(2'd3 - addr_lo_q);
            end
            LD_WR: begin
                shifted = data_rdata >> {addr_lo_q, 3'b000};
                wb_mask = 4'b1111 >> addr_lo_q;
            end
            default: wb_data = res_q;
        endcase
        if (ld_op_q == LD_WL || ld_op_q == LD_WR) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                wb_data[8*i +: 8] = wb_mask[i] ? shifted[8*i +: 8] : rt_val_q[8*i +: 8];
            end
        end
    end

    assign rf_we             = (write_cycle && wr_en) ? wb_mask : 4'b0000;
    assign rf_waddr          = dest_q;
    assign rf_wdata          = wb_data;
    assign ws_fwd_valid      = wr_en;
    assign ws_fwd_dest       = wr_en ? dest_q : '0;
    assign ws_fwd_data_ok    = wr_en & ws_ready_go;
    assign ws_fwd_data       = wb_data;
    assign debug_wb_pc       = ws_valid_q ? pc_q : 32'h0;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage: a driver issues instructions, a responder
// returns load data after a chosen delay, a monitor checks retirements in order.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_rdata_ok;
    logic [31:0] data_rdata;
    logic [3:0]  rf_we, debug_wb_rf_wen;
    logic [4:0]  rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, ws_fwd_data, debug_wb_pc, debug_wb_rf_wdata;
    logic        ws_fwd_valid, ws_fwd_data_ok;

    wb_stage_if #(.DATA_W(32), .ADDR_W(5)) ms_if ();

    wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .ms(ms_if.slave),
        .data_rdata_ok(data_rdata_ok), .data_rdata(data_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest),
        .ws_fwd_data_ok(ws_fwd_data_ok), .ws_fwd_data(ws_fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  op;
        logic [1:0]  a;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          delay;
    } item_t;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] wdata;
        int          delay;
        int          acc_cyc;
    } exp_t;

    exp_t  sb_q[$];
    item_t rsp_q[$];
    item_t items[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: assemble the written word byte by byte from the load rules.
    function automatic exp_t model(input item_t it);
        exp_t        e;
        logic [7:0]  r[4];
        logic [7:0]  d[4];
        logic [3:0]  m;
        logic [15:0] h;
        int          ai;
        ai = int'(it.a);
        for (int i = 0; i < 4; i++) begin
            r[i] = it.rdata[8*i +: 8];
            d[i] = it.rt[8*i +: 8];
        end
        m = 4'b1111;
        h = {r[2*int'(it.a[1]) + 1], r[2*int'(it.a[1])]};
        case (it.op)
            3'd1: e.wdata = {{24{r[ai][7]}}, r[ai]};
            3'd2: e.wdata = {24'h0, r[ai]};
            3'd3: e.wdata = {{16{h[15]}}, h};
            3'd4: e.wdata = {16'h0, h};
            3'd5: e.wdata = it.rdata;
            3'd6: begin
                for (int i = 0; i < 4; i++) begin
                    m[i] = (i >= 3 - ai);
                    if (m[i]) d[i] = r[i - (3 - ai)];
                end
                e.wdata = {d[3], d[2], d[1], d[0]};
            end
            3'd7: begin
                for (int i = 0; i < 4; i++) begin
                    m[i] = (i <= 3 - ai);
                    if (m[i]) d[i] = r[i + ai];
                end
                e.wdata = {d[3], d[2], d[1], d[0]};
            end
            default: e.wdata = it.res;
        endcase
        e.pc      = it.pc;
        e.dest    = it.dest;
        e.we      = (it.gr_we && it.dest != 5'd0) ? m : 4'b0000;
        e.delay   = (it.op == 3'd0) ? 0 : it.delay;
        e.acc_cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: returns data for the load currently in the stage after its delay.
    always @(posedge clk) begin
        #1;
        data_rdata_ok = 1'b0;
        data_rdata    = $urandom;
        if (rsp_q.size() > 0 && debug_wb_pc == rsp_q[0].pc) begin
            if (rsp_q[0].delay == 0) begin
                data_rdata_ok = 1'b1;
                data_rdata    = rsp_q[0].rdata;
                void'(rsp_q.pop_front());
            end else begin
                rsp_q[0].delay = rsp_q[0].delay - 1;
            end
        end
    end

    // Monitor: checks the head of the scoreboard whenever its PC is in the stage.
    bit seen = 1'b0;
    int stalls = 0;
    int idle = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && debug_wb_pc == sb_q[0].pc) begin
                idle = 0;
                if (!seen) begin
                    chk("accept_latency", 32'(cyc), 32'(sb_q[0].acc_cyc + 1));
                    seen   = 1'b1;
                    stalls = 0;
                end
                if (ms_if.ws_allowin) begin
                    chk("stall_cycles", 32'(stalls), 32'(sb_q[0].delay));
                    chk("rf_we", 32'(rf_we), 32'(sb_q[0].we));
                    chk("rf_waddr", 32'(rf_waddr), 32'(sb_q[0].dest));
                    chk("rf_wdata", rf_wdata, sb_q[0].wdata);
                    chk("fwd_valid", 32'(ws_fwd_valid), 32'(sb_q[0].we != 4'b0));
                    chk("fwd_dest", 32'(ws_fwd_dest), (sb_q[0].we != 4'b0) ? 32'(sb_q[0].dest) : 32'h0);
                    if (sb_q[0].we != 4'b0) begin
                        chk("fwd_data_ok", 32'(ws_fwd_data_ok), 32'h1);
                        chk("fwd_data", ws_fwd_data, sb_q[0].wdata);
                    end
                    chk("dbg_wen", 32'(debug_wb_rf_wen), 32'(sb_q[0].we));
                    chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(sb_q[0].dest));
                    chk("dbg_wdata", debug_wb_rf_wdata, sb_q[0].wdata);
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end else begin
                    chk("stall_rf_we", 32'(rf_we), 32'h0);
                    chk("stall_fwd_ok", 32'(ws_fwd_data_ok), 32'h0);
                    stalls++;
                    if (stalls > 20) begin
                        chk("stall_timeout", 32'h1, 32'h0);
                        sb_q.delete();
                        seen = 1'b0;
                    end
                end
            end else if (debug_wb_pc != 32'h0) begin
                chk("unexpected_pc", debug_wb_pc, (sb_q.size() > 0) ? sb_q[0].pc : 32'h0);
            end else if (sb_q.size() > 0) begin
                idle++;
                if (idle > 40) begin
                    chk("sb_timeout", 32'h1, 32'h0);
                    sb_q.delete();
                    idle = 0;
                end
            end
        end
    end

    function automatic item_t mk(input logic [2:0] op, input logic [1:0] a, input logic gr_we,
                                 input logic [4:0] dest, input logic [31:0] res,
                                 input logic [31:0] rt, input logic [31:0] rdata, input int delay);
        item_t it;
        it.pc = 32'h0; it.op = op; it.a = a; it.gr_we = gr_we; it.dest = dest;
        it.res = res; it.rt = rt; it.rdata = rdata; it.delay = delay;
        return it;
    endfunction

    task automatic idle_inputs();
        ms_if.ms_to_ws_valid = 1'b0;
        ms_if.ms_pc = '0; ms_if.ms_gr_we = 1'b0; ms_if.ms_dest = '0; ms_if.ms_res = '0;
        ms_if.ms_ld_op = '0; ms_if.ms_addr_lo = '0; ms_if.ms_rt_val = '0;
    endtask

    task automatic present(input item_t it);
        ms_if.ms_to_ws_valid = 1'b1;
        ms_if.ms_pc = it.pc; ms_if.ms_gr_we = it.gr_we; ms_if.ms_dest = it.dest;
        ms_if.ms_res = it.res; ms_if.ms_ld_op = it.op; ms_if.ms_addr_lo = it.a;
        ms_if.ms_rt_val = it.rt;
    endtask

    int n_directed;
    initial begin
        item_t it;
        exp_t  e;
        bit    acc;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rf_we", 32'(rf_we), 32'h0);
        chk("reset_allowin", 32'(ms_if.ws_allowin), 32'h1);
        chk("reset_dbg_pc", debug_wb_pc, 32'h0);
        chk("reset_fwd_valid", 32'(ws_fwd_valid), 32'h0);
        chk("reset_wdata", rf_wdata, 32'h0);
        chk("reset_waddr", 32'(rf_waddr), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        items.push_back(mk(3'd0, 2'd0, 1'b1, 5'd5,  32'h12345678, 32'h0, 32'h0, 0));
        items.push_back(mk(3'd1, 2'd2, 1'b1, 5'd7,  32'h0, 32'h0, 32'h0080FF00, 2));
        items.push_back(mk(3'd2, 2'd2, 1'b1, 5'd8,  32'h0, 32'h0, 32'h0080FF00, 2));
        items.push_back(mk(3'd6, 2'd1, 1'b1, 5'd9,  32'h0, 32'hAABBCCDD, 32'h11223344, 0));
        items.push_back(mk(3'd7, 2'd1, 1'b1, 5'd10, 32'h0, 32'hAABBCCDD, 32'h11223344, 1));
        items.push_back(mk(3'd0, 2'd0, 1'b1, 5'd0,  32'hDEADBEEF, 32'h0, 32'h0, 0));
        for (int i = 0; i < 6; i++)
            items.push_back(mk(3'd0, 2'd0, 1'b1, 5'(i + 1), 32'(i * 32'h01010101), 32'h0, 32'h0, 0));
        n_directed = items.size();
        for (int i = 0; i < 300; i++) begin
            it = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom, $urandom_range(0, 3));
            if (it.op == 3'd3 || it.op == 3'd4) it.a[0] = 1'b0;
            if (it.op == 3'd5) it.a = 2'd0;
            items.push_back(it);
        end

        for (int i = 0; i < items.size(); i++) begin
            it    = items[i];
            it.pc = 32'hBFC0_0000 + 32'(i * 4);
            if (i >= n_directed) begin
                repeat ($urandom_range(0, 2)) begin
                    ms_if.ms_to_ws_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            present(it);
            acc = 1'b0;
            for (int w = 0; w < 50 && !acc; w++) begin
                @(negedge clk);
                if (ms_if.ws_allowin) begin
                    acc       = 1'b1;
                    e         = model(it);
                    e.acc_cyc = cyc;
                    sb_q.push_back(e);
                    if (it.op != 3'd0) rsp_q.push_back(it);
                end
                @(posedge clk); #1;
            end
            if (!acc) chk("accept_timeout", 32'h0, 32'h1);
        end
        idle_inputs();
        for (int w = 0; w < 200 && sb_q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'h0);
        mon_en = 1'b0;

        // Reset while a load waits for data: nothing is written and the stage empties.
        it    = mk(3'd5, 2'd0, 1'b1, 5'd3, 32'h0, 32'h0, 32'hCAFEF00D, 1000);
        it.pc = 32'h8000_0040;
        rsp_q.push_back(it);
        @(posedge clk); #1;
        present(it);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("stall_allowin", 32'(ms_if.ws_allowin), 32'h0);
        chk("stall_dbg_pc", debug_wb_pc, 32'h8000_0040);
        chk("stall_we", 32'(rf_we), 32'h0);
        chk("stall_fwd_valid", 32'(ws_fwd_valid), 32'h1);
        chk("stall_fwd_dest", 32'(ws_fwd_dest), 32'h3);
        chk("stall_fwd_ok0", 32'(ws_fwd_data_ok), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_we", 32'(rf_we), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_q.delete();
        @(negedge clk);
        chk("post_rst_dbg_pc", debug_wb_pc, 32'h0);
        chk("post_rst_we", 32'(rf_we), 32'h0);
        chk("post_rst_allowin", 32'(ms_if.ws_allowin), 32'h1);
        chk("post_rst_fwd", 32'(ws_fwd_valid), 32'h0);
        chk("post_rst_waddr", 32'(rf_waddr), 32'h0);
        chk("post_rst_wdata", rf_wdata, 32'h0);
        @(negedge clk);
        chk("post_rst_idle_we", 32'(rf_we), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
